// File: rtl/led_bar_pkg.sv
// Shared types and pattern helpers for the LED-bar sequencer.
package led_bar_pkg;

  typedef enum logic [1:0] {
    FILL_DRAIN = 2'd0,
    SCAN       = 2'd1,
    COUNT      = 2'd2,
    BLINK      = 2'd3
  } led_mode_e;

  localparam int unsigned MAX_LEDS = 16;

  function automatic int unsigned period(led_mode_e m, int unsigned n);
    case (m)
      FILL_DRAIN, SCAN: return 32'd2 * n - 32'd2;
      COUNT:            return 32'd1 << n;
      default:          return 32'd2;
    endcase
  endfunction

  // Bit i set means LED i lit; polarity is applied by the caller.
  function automatic logic [MAX_LEDS-1:0] pattern(led_mode_e m, int unsigned p, int unsigned n);
    logic [31:0] all;
    logic [31:0] bits;
    all = (32'd1 << n) - 32'd1;
    case (m)
      FILL_DRAIN: bits = (p < n) ? ((32'd1 << (p + 32'd1)) - 32'd1)
                                 : ((all << (p - n + 32'd2)) & all);
      SCAN:       bits = 32'd1 << ((p < n) ? p : (32'd2 * n - 32'd2 - p));
      COUNT:      bits = p;
      default:    bits = (p == 32'd0) ? all : '0;
    endcase
    return MAX_LEDS'(bits & all);
  endfunction

endpackage

// File: rtl/led_bar_sequencer_if.sv
// Control/status bundle of the LED-bar sequencer; brightness exists only with LED_PWM_EN.
interface led_bar_sequencer_if
  import led_bar_pkg::*;
#(
  parameter int unsigned N_LEDS = 6
);
  logic              en;
  logic              pause;
  led_mode_e         mode;
  logic [N_LEDS-1:0] leds;
  logic              step_pulse;
  logic              wrap;
`ifdef LED_PWM_EN
  logic [3:0]        brightness;
`endif

  modport master (
    output en, pause, mode,
`ifdef LED_PWM_EN
    output brightness,
`endif
    input  leds, step_pulse, wrap
  );

  modport slave (
    input  en, pause, mode,
`ifdef LED_PWM_EN
    input  brightness,
`endif
    output leds, step_pulse, wrap
  );
endinterface

// File: rtl/led_bar_sequencer_tick_gen.sv
// Step prescaler: counts 0..DIV-1 and flags the last count as the step tick.
module led_tick_gen #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic hold,
  output logic tick
);
  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (!hold) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/led_bar_sequencer.sv
// Parametrised LED-bar pattern engine: prescaled phase counter mapped to an N-LED pattern.
// Optional LED_PWM_EN adds a brightness input gating lit LEDs with a 4-bit PWM.
module led_bar_sequencer
  import led_bar_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 27_000_000,
  parameter int unsigned STEP_HZ    = 2,
  parameter int unsigned N_LEDS     = 6,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input logic                clk,
  input logic                rst,
  led_bar_sequencer_if.slave bus
);
  localparam int unsigned       DIV   = CLK_HZ / STEP_HZ;
  localparam int unsigned       PW    = N_LEDS;
  localparam logic [N_LEDS-1:0] UNLIT = ACTIVE_LOW ? '1 : '0;

  if (DIV < 2) begin : g_div_chk
    $error("led_bar_sequencer: CLK_HZ/STEP_HZ must be >= 2");
  end
  if (N_LEDS < 2 || N_LEDS > MAX_LEDS) begin : g_n_chk
    $error("led_bar_sequencer: N_LEDS must be in 2..16");
  end

  logic              tick;
  logic              pwm_on;
  logic [PW-1:0]     phase_q, phase_d;
  led_mode_e         mode_q, mode_d;
  logic [N_LEDS-1:0] lit_q, lit_d;
  logic [N_LEDS-1:0] lit_on;
  logic [N_LEDS-1:0] leds_q, leds_d;
  logic              step_pulse_q, step_pulse_d;
  logic              wrap_q, wrap_d;

  led_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (!bus.en),
    .hold (bus.pause),
    .tick (tick)
  );

`ifdef LED_PWM_EN
  logic [3:0] pwm_cnt_q, pwm_cnt_d;

  always_comb pwm_cnt_d = pwm_cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt_q <= '0;
    else     pwm_cnt_q <= pwm_cnt_d;
  end

  assign pwm_on = (pwm_cnt_q < bus.brightness);
`else
  assign pwm_on = 1'b1;
`endif

  // The pattern is loaded from the next-state phase so the new LEDs appear
  // in the same cycle as step_pulse; phase itself is never visible outside.
  always_comb begin
    phase_d      = phase_q;
    mode_d       = mode_q;
    lit_d        = lit_q;
    step_pulse_d = 1'b0;
    wrap_d       = 1'b0;
    if (!bus.en) begin
      phase_d = '0;
      mode_d  = bus.mode;
      lit_d   = '0;
    end else if (!bus.pause) begin
      if (tick) begin
        step_pulse_d = 1'b1;
        if (bus.mode != mode_q) begin
          mode_d  = bus.mode;
          phase_d = '0;
        end else if (32'(phase_q) == period(mode_q, N_LEDS) - 32'd1) begin
          phase_d = '0;
          wrap_d  = 1'b1;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      lit_d = N_LEDS'(pattern(mode_d, 32'(phase_d), N_LEDS));
    end
    lit_on = lit_d & {N_LEDS{pwm_on}};
    leds_d = ACTIVE_LOW ? ~lit_on : lit_on;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q      <= '0;
      mode_q       <= FILL_DRAIN;
      lit_q        <= '0;
      leds_q       <= UNLIT;
      step_pulse_q <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      mode_q       <= mode_d;
      lit_q        <= lit_d;
      leds_q       <= leds_d;
      step_pulse_q <= step_pulse_d;
      wrap_q       <= wrap_d;
    end
  end

  assign bus.leds       = leds_q;
  assign bus.step_pulse = step_pulse_q;
  assign bus.wrap       = wrap_q;
endmodule

// File: tb/tb_led_bar_sequencer.sv
// Scoreboard bench for led_bar_sequencer (DIV=8, 6 LEDs, active-low, default build).
module tb_led_bar_sequencer;
  import led_bar_pkg::*;

  localparam int unsigned N    = 6;
  localparam int unsigned DIVN = 8;

  typedef struct {
    int unsigned   cyc;
    logic [N-1:0]  leds;
    logic          step;
    logic          wrap;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  ev_t         q[$];

  int unsigned  m_cnt;
  int unsigned  m_ph;
  int           m_mq;
  logic [N-1:0] m_prev;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  led_bar_sequencer_if #(.N_LEDS(N)) bus ();

  led_bar_sequencer #(
    .CLK_HZ     (8),
    .STEP_HZ    (1),
    .N_LEDS     (N),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic int unsigned ref_period(int m);
    case (m)
      0, 1:    return 2 * N - 2;
      2:       return 1 << N;
      default: return 2;
    endcase
  endfunction

  // Lit set written directly from the pattern rules, LED by LED.
  function automatic logic [N-1:0] ref_lit(int m, int unsigned p);
    logic [N-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < N; i++) begin
      case (m)
        0:       r[i] = (p < N) ? (i <= p) : (i + N >= p + 2);
        1:       r[i] = (i == ((p < N) ? p : 2 * N - 2 - p));
        2:       r[i] = p[i];
        default: r[i] = (p == 0);
      endcase
    end
    return r;
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_ph   = 0;
    m_mq   = 0;
    m_prev = '1;
  endtask

  task automatic model_step(input bit en, input bit pause, input int m);
    logic         step, wr;
    logic [N-1:0] lv;
    step = 1'b0;
    wr   = 1'b0;
    lv   = m_prev;
    if (!en) begin
      m_cnt = 0;
      m_ph  = 0;
      m_mq  = m;
      lv    = '1;
    end else if (!pause) begin
      if (m_cnt == DIVN - 1) begin
        m_cnt = 0;
        step  = 1'b1;
        if (m != m_mq) begin
          m_mq = m;
          m_ph = 0;
        end else begin
          m_ph = (m_ph + 1) % ref_period(m_mq);
          wr   = (m_ph == 0);
        end
      end else begin
        m_cnt++;
      end
      lv = ~ref_lit(m_mq, m_ph);
    end
    if (step || lv != m_prev) q.push_back('{cyc + 1, lv, step, wr});
    m_prev = lv;
  endtask

  task automatic drive_cycle(input bit en, input bit pause, input int m);
    bus.en    = en;
    bus.pause = pause;
    bus.mode  = led_mode_e'(m[1:0]);
    model_step(en, pause, m);
    @(negedge clk);
  endtask

  task automatic run(input int m, input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b0, m);
  endtask

  task automatic check_reset_state(input string tag);
    checks++;
    if (bus.leds !== 6'b111111 || bus.step_pulse !== 1'b0 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL %s: leds=%b step=%b wrap=%b, required leds=111111 step=0 wrap=0",
               tag, bus.leds, bus.step_pulse, bus.wrap);
    end
  endtask

  task automatic reset_dut();
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_state("async_reset");
    @(negedge clk);
    @(negedge clk);
    check_reset_state("reset_hold");
    rst = 1'b0;
    model_reset();
    q.delete();
    mon_en = 1'b1;
  endtask

  initial begin : monitor
    logic [N-1:0] prev;
    ev_t          e;
    prev = '1;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.step_pulse || bus.wrap || bus.leds != prev) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event cyc=%0d: leds=%b step=%b wrap=%b, required no change",
                     cyc, bus.leds, bus.step_pulse, bus.wrap);
          end else begin
            e = q.pop_front();
            if (e.cyc != cyc || e.leds !== bus.leds || e.step !== bus.step_pulse || e.wrap !== bus.wrap) begin
              errors++;
              $display("FAIL event: cyc=%0d leds=%b step=%b wrap=%b, required cyc=%0d leds=%b step=%b wrap=%b",
                       cyc, bus.leds, bus.step_pulse, bus.wrap, e.cyc, e.leds, e.step, e.wrap);
            end
          end
        end else if (q.size() != 0 && q[0].cyc <= cyc) begin
          checks++;
          errors++;
          $display("FAIL missed_event cyc=%0d: leds=%b step=0, required leds=%b step=%b wrap=%b",
                   cyc, bus.leds, q[0].leds, q[0].step, q[0].wrap);
          void'(q.pop_front());
        end
      end
      prev = bus.leds;
    end
  end

  initial begin : driver
    int en_off, pz, m, r;
    bus.en    = 1'b1;
    bus.pause = 1'b0;
    bus.mode  = FILL_DRAIN;
    repeat (3) @(negedge clk);
    check_reset_state("power_on_reset");
    rst = 1'b0;
    model_reset();
    mon_en = 1'b1;

    run(0, 200);
    run(0, 37);
    reset_dut();
    run(0, 120);
    run(1, 200);
    run(0, 36);
    run(2, 600);
    run(0, 28);
    for (int i = 0; i < 20; i++) drive_cycle(1'b1, 1'b1, 0);
    run(0, 100);
    for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b0, 0);
    run(0, 40);
    run(3, 80);

    en_off = 0;
    pz     = 0;
    m      = 3;
    for (int c = 0; c < 3000; c++) begin
      if (en_off == 0 && pz == 0) begin
        r = int'($urandom_range(0, 999));
        if (r < 15)      en_off = int'($urandom_range(1, 6));
        else if (r < 45) pz = int'($urandom_range(1, 25));
        else if (r < 60) m = int'($urandom_range(0, 3));
        else if (r < 62) reset_dut();
      end
      drive_cycle(en_off == 0, (pz != 0) || (en_off != 0 && r[0]), m);
      if (en_off != 0)  en_off--;
      else if (pz != 0) pz--;
    end

    run(m, 4);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: %0d left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
